// File: rtl/sdf_tag_demux_if.sv
// Handshake bundle between an upstream tagged-token FIFO, the tag demux and its
// per-flux downstream FIFOs.
interface sdf_tag_demux_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FLUX       = 2
);
  localparam int unsigned TAG_WIDTH = (FLUX > 1) ? $clog2(FLUX) : 1;
  localparam int unsigned WIDTH     = DATA_WIDTH + TAG_WIDTH;

  logic                       in_empty;
  logic                       in_read;
  logic [WIDTH-1:0]           in_dout;
  logic [FLUX-1:0]            out_full;
  logic [FLUX-1:0]            out_write;
  logic [FLUX*DATA_WIDTH-1:0] out_din;
  logic [FLUX-1:0]            out_last;
  logic                       tag_err;

  // FIFO side: supplies tokens and full flags, observes strobes.
  modport master (
    output in_empty, in_dout, out_full,
    input  in_read, out_write, out_din, out_last, tag_err
  );

  // Demux side.
  modport slave (
    input  in_empty, in_dout, out_full,
    output in_read, out_write, out_din, out_last, tag_err
  );
endinterface

// File: rtl/sdf_tag_demux.sv
// Splits a tagged {tag, data} token stream into per-flux FIFOs through a
// one-entry holding stage, marking the last token of every NUM_OP-token frame.
module sdf_tag_demux #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FLUX       = 2,
  parameter int unsigned NUM_OP     = 4
) (
  input logic               clk,
  input logic               rst,
  sdf_tag_demux_if.slave    bus_io
);
  localparam int unsigned TAG_WIDTH = (FLUX > 1) ? $clog2(FLUX) : 1;
  localparam int unsigned WIDTH     = DATA_WIDTH + TAG_WIDTH;
  localparam int unsigned NumOpEff  = (NUM_OP == 0) ? 1 : NUM_OP;
  localparam int unsigned CntWidth  = (NumOpEff > 1) ? $clog2(NumOpEff) : 1;
  localparam logic [CntWidth-1:0] CntLoad = CntWidth'(NumOpEff - 1);

  logic                  hold_valid_q, hold_valid_d;
  logic [TAG_WIDTH-1:0]  hold_tag_q, hold_tag_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic [CntWidth-1:0]   cnt_q [FLUX];
  logic [CntWidth-1:0]   cnt_d [FLUX];
  logic                  tag_err_q, tag_err_d;

  logic [TAG_WIDTH-1:0]  in_tag;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  tag_ok;
  logic                  sel_full, sel_last;
  logic                  drain, in_read;
  logic [FLUX-1:0]       write_vec, last_vec;

  assign in_tag  = bus_io.in_dout[WIDTH-1:DATA_WIDTH];
  assign in_data = bus_io.in_dout[DATA_WIDTH-1:0];
  // With a single flux the tag bit carries no information and is ignored.
  assign tag_ok  = (FLUX == 1) || (32'(in_tag) < FLUX);

  always_comb begin
    sel_full = 1'b0;
    sel_last = 1'b0;
    for (int f = 0; f < FLUX; f++) begin
      if (hold_tag_q == TAG_WIDTH'(f)) begin
        sel_full = bus_io.out_full[f];
        sel_last = (cnt_q[f] == '0);
      end
    end
  end

  assign drain   = ~rst & hold_valid_q & ~sel_full;
  assign in_read = ~rst & ~bus_io.in_empty & (~hold_valid_q | drain);

  always_comb begin
    write_vec = '0;
    last_vec  = '0;
    for (int f = 0; f < FLUX; f++) begin
      if (hold_tag_q == TAG_WIDTH'(f)) begin
        write_vec[f] = drain;
        last_vec[f]  = drain & sel_last;
      end
    end
  end

  assign bus_io.in_read   = in_read;
  assign bus_io.out_write = write_vec;
  assign bus_io.out_last  = last_vec;
  assign bus_io.out_din   = {FLUX{hold_data_q}};
  assign bus_io.tag_err   = tag_err_q;

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_tag_d   = hold_tag_q;
    hold_data_d  = hold_data_q;
    tag_err_d    = tag_err_q;
    cnt_d        = cnt_q;
    if (drain) begin
      hold_valid_d = 1'b0;
    end
    if (in_read) begin
      if (tag_ok) begin
        hold_valid_d = 1'b1;
        hold_tag_d   = (FLUX == 1) ? '0 : in_tag;
        hold_data_d  = in_data;
      end else begin
        // Illegal tag: token is consumed and dropped; the slot is free here.
        hold_valid_d = 1'b0;
        tag_err_d    = 1'b1;
      end
    end
    for (int f = 0; f < FLUX; f++) begin
      if (drain && (hold_tag_q == TAG_WIDTH'(f))) begin
        cnt_d[f] = (cnt_q[f] == '0) ? CntLoad : cnt_q[f] - CntWidth'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_tag_q   <= '0;
      hold_data_q  <= '0;
      tag_err_q    <= 1'b0;
      for (int f = 0; f < FLUX; f++) begin
        cnt_q[f] <= CntLoad;
      end
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_tag_q   <= hold_tag_d;
      hold_data_q  <= hold_data_d;
      tag_err_q    <= tag_err_d;
      cnt_q        <= cnt_d;
    end
  end
endmodule

// File: tb/tb_sdf_tag_demux.sv
// Scoreboard bench for sdf_tag_demux (FLUX=3 so tag 3 is illegal): directed
// scenarios plus randomized traffic with random empty gaps and full flags.
module tb_sdf_tag_demux;
  localparam int unsigned DW  = 8;
  localparam int unsigned FL  = 3;
  localparam int unsigned NOP = 4;
  localparam int unsigned W   = DW + 2;

  typedef struct {
    int          tag;
    logic [7:0]  data;
    bit          last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sdf_tag_demux_if #(.DATA_WIDTH(DW), .FLUX(FL)) bus ();

  sdf_tag_demux #(.DATA_WIDTH(DW), .FLUX(FL), .NUM_OP(NOP)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  exp_t           exp_q[$];
  logic [W-1:0]   src_q[$];
  int             model_cnt [FL];
  int             last_seen [FL];
  int             n_cmp  = 0;
  int             n_fail = 0;
  bit             src_en = 1'b1;
  bit             rd_pending = 1'b0;
  exp_t           mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void drive();
    bus.in_empty = !(src_en && (src_q.size() > 0));
    bus.in_dout  = (src_q.size() > 0) ? src_q[0] : '0;
  endfunction

  // Reference: writes come out in token order; a flux's Nth legal token is a
  // frame end when N is a multiple of NUM_OP.
  task automatic push_tok(input int tag, input logic [7:0] data);
    logic [1:0] t2;
    exp_t e;
    t2 = tag[1:0];
    src_q.push_back({t2, data});
    if (tag < FL) begin
      model_cnt[tag]++;
      e.tag  = tag;
      e.data = data;
      e.last = (model_cnt[tag] % NOP) == 0;
      exp_q.push_back(e);
    end
    drive();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rd_pending && (src_q.size() > 0)) void'(src_q.pop_front());
    drive();
  endtask

  task automatic flush_model();
    src_q.delete();
    exp_q.delete();
    for (int f = 0; f < FL; f++) begin
      model_cnt[f] = 0;
      last_seen[f] = 0;
    end
    drive();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    flush_model();
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    src_en = 1'b1;
    bus.out_full = '0;
    drive();
    k = 0;
    while (((exp_q.size() > 0) || (src_q.size() > 0)) && (k < 500)) begin
      step();
      k++;
    end
    check("drain_timeout", 32'(k < 500), 32'd1);
    step();
    step();
  endtask

  always @(negedge clk) rd_pending = bus.in_read & ~rst;

  // Monitor: every write is matched against the head of the expected queue.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_quiet", {bus.in_read, bus.out_write}, 32'd0);
    end else if (bus.out_write != '0) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: got out_write=%b din=%h, required no write (t=%0t)",
                 bus.out_write, bus.out_din, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_dest", 32'(bus.out_write), 32'(1) << mon_e.tag);
        check("write_data", 32'(bus.out_din[mon_e.tag*DW +: DW]), 32'(mon_e.data));
        check("write_last", 32'(bus.out_last), mon_e.last ? (32'(1) << mon_e.tag) : 32'd0);
      end
      for (int f = 0; f < FL; f++) if (bus.out_last[f]) last_seen[f]++;
    end else begin
      check("idle_last", 32'(bus.out_last), 32'd0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    logic [2:0] wr_tab [4];
    logic       rd_tab [4];
    int         t;

    // Reset with tokens already waiting upstream.
    rst = 1'b1;
    bus.out_full = '0;
    flush_model();
    push_tok(0, 8'h11);
    push_tok(2, 8'h22);
    step();
    repeat (2) begin
      @(negedge clk);
      check("rst_in_read", 32'(bus.in_read), 32'd0);
      check("rst_din_zero", 32'(bus.out_din), 32'd0);
      step();
    end
    rst = 1'b0;
    @(negedge clk);
    check("first_read_after_rst", 32'(bus.in_read), 32'd1);
    check("tag_err_after_rst", 32'(bus.tag_err), 32'd0);
    wait_drain();

    // Back-to-back streaming: three reads, writes one cycle later.
    push_tok(1, 8'h05);
    push_tok(0, 8'h0A);
    push_tok(1, 8'h07);
    rd_tab = '{1'b1, 1'b1, 1'b1, 1'b0};
    wr_tab = '{3'b000, 3'b010, 3'b001, 3'b010};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stream_in_read", 32'(bus.in_read), 32'(rd_tab[i]));
      check("stream_out_write", 32'(bus.out_write), 32'(wr_tab[i]));
      step();
    end
    wait_drain();

    // Backpressure on flux 1 blocks everything behind it.
    bus.out_full = 3'b010;
    push_tok(1, 8'h33);
    push_tok(0, 8'h21);
    @(negedge clk);
    check("bp_first_read", 32'(bus.in_read), 32'd1);
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_stall_write", 32'(bus.out_write), 32'd0);
      check("bp_stall_read", 32'(bus.in_read), 32'd0);
      check("bp_stall_data", 32'(bus.out_din[DW +: DW]), 32'h33);
      step();
    end
    bus.out_full = '0;
    @(negedge clk);
    check("bp_release_write", 32'(bus.out_write), 32'b010);
    check("bp_release_read", 32'(bus.in_read), 32'd1);
    step();
    @(negedge clk);
    check("bp_next_write", 32'(bus.out_write), 32'b001);
    step();
    wait_drain();

    // Frame markers: 8 flux-0 tokens interleaved with 3 flux-1 tokens.
    do_reset(1);
    push_tok(0, 8'h40); push_tok(1, 8'h50); push_tok(0, 8'h41); push_tok(0, 8'h42);
    push_tok(1, 8'h51); push_tok(0, 8'h43); push_tok(0, 8'h44); push_tok(0, 8'h45);
    push_tok(1, 8'h52); push_tok(0, 8'h46); push_tok(0, 8'h47);
    wait_drain();
    check("frame_last0_count", 32'(last_seen[0]), 32'd2);
    check("frame_last1_count", 32'(last_seen[1]), 32'd0);
    push_tok(1, 8'h53);
    wait_drain();
    check("frame_last1_fourth", 32'(last_seen[1]), 32'd1);

    // Illegal tag is consumed, dropped, and flagged until reset.
    do_reset(1);
    push_tok(3, 8'h44);
    push_tok(2, 8'h55);
    push_tok(0, 8'h66);
    @(negedge clk);
    check("bad_tag_read", 32'(bus.in_read), 32'd1);
    step();
    @(negedge clk);
    check("bad_tag_no_write", 32'(bus.out_write), 32'd0);
    check("bad_tag_flag", 32'(bus.tag_err), 32'd1);
    wait_drain();
    check("bad_tag_sticky", 32'(bus.tag_err), 32'd1);
    do_reset(1);
    @(negedge clk);
    check("bad_tag_cleared", 32'(bus.tag_err), 32'd0);

    // Reset while a token is stalled and flux 0 is mid-frame.
    do_reset(1);
    push_tok(0, 8'h90);
    push_tok(0, 8'h91);
    wait_drain();
    bus.out_full = 3'b001;
    push_tok(0, 8'h99);
    repeat (3) step();
    @(negedge clk);
    check("mid_rst_stalled", 32'(bus.out_write), 32'd0);
    step();
    do_reset(1);
    bus.out_full = '0;
    repeat (5) step();
    push_tok(0, 8'hA0); push_tok(0, 8'hA1); push_tok(0, 8'hA2); push_tok(0, 8'hA3);
    wait_drain();
    check("mid_rst_frame_restart", 32'(last_seen[0]), 32'd1);

    // Randomized traffic with upstream gaps and random downstream full.
    do_reset(1);
    for (int i = 0; i < 600; i++) begin
      if (($urandom_range(0, 2) != 0) && (src_q.size() < 8)) begin
        t = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
        push_tok(t, 8'($urandom_range(0, 255)));
      end
      src_en = ($urandom_range(0, 4) != 0);
      for (int f = 0; f < FL; f++) bus.out_full[f] = ($urandom_range(0, 3) == 0);
      drive();
      step();
    end
    wait_drain();
    check("random_exp_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/sdf_tag_demux.md
Name: sdf_tag_demux

Overview:
- Consumer-side counterpart of the multi-flux SDF actor.
- Reads the single tagged token stream that the actor writes into its output FIFO (each token is {tag, data}).
- Strips the tag and dispatches the data to one of FLUX per-flux output FIFOs.
- Marks the last token of every NUM_OP-token frame per flux; a one-entry holding stage decouples input reads from output backpressure.

Parameters:
- DATA_WIDTH, 8, payload width per token.
- FLUX, 2, number of fluxes / output FIFOs.
- NUM_OP, 4, tokens per frame per flux; 0 is treated as 1.
- TAG_WIDTH, $clog2(FLUX) (minimum 1), derived, tag field width.
- WIDTH, DATA_WIDTH+TAG_WIDTH, derived, input token width.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- in_empty  input  1  upstream FIFO empty.
- in_read  output  1  upstream FIFO read strobe.
- in_dout  input  WIDTH  upstream FIFO data, first-word fall-through, valid when in_empty=0; tag in [WIDTH-1:DATA_WIDTH], data in [DATA_WIDTH-1:0].
- out_full  input  FLUX  per-flux downstream FIFO full; bit f belongs to flux f.
- out_write  output  FLUX  per-flux write strobe, at most one bit high per cycle.
- out_din  output  FLUX*DATA_WIDTH  per-flux data; slice f = [f*DATA_WIDTH +: DATA_WIDTH].
- out_last  output  FLUX  frame-end marker, qualified by out_write[f].
- tag_err  output  1  sticky flag: an illegal tag was received.

Behaviour:
- State:
  - holding register hold_valid / hold_tag / hold_data;
  - per-flux counters cnt[f], each $clog2(NUM_OP) bits (minimum 1);
  - tag_err flop.
- Output side (combinational from the holding register):
  - drain = hold_valid & ~out_full[hold_tag].
  - out_write[hold_tag] = drain; all other out_write bits = 0.
  - Every out_din slice carries hold_data (broadcast); only out_write selects the destination.
  - out_last[hold_tag] = drain & (cnt[hold_tag]==0); all other out_last bits = 0.
- Input side:
  - in_read = ~rst & ~in_empty & (~hold_valid | drain).
  - Read and drain may occur in the same cycle, giving a throughput of 1 token/cycle.
- Capture at posedge when in_read=1:
  - If the tag is less than FLUX: hold_valid<=1, hold_tag<=tag, hold_data<=data.
  - Otherwise the token is consumed and dropped: hold_valid<=0, unless it was already set and not draining (impossible, because in_read requires a free slot), and tag_err<=1.
- At posedge with drain=1 and no capture: hold_valid<=0.
- Latency: a token read at edge N is presented on out_write in the cycle after edge N (1 cycle).
- Counters:
  - Reset value: NUM_OP-1.
  - On each drain to flux f: if cnt[f]==0, reload NUM_OP-1, else decrement.
  - Counters of other fluxes hold.
- Backpressure:
  - While out_full[hold_tag]=1 the token stays held and in_read=0 (head-of-line blocking across all fluxes, intentional).
  - out_din and hold contents remain stable during the stall.
- Empty: with in_empty=1, in_read=0; a held token still drains if its FIFO is not full.
- Reset (synchronous, any time, including mid-stall):
  - hold_valid=0, cnt[f]=NUM_OP-1 for all f, tag_err=0.
  - in_read=0 and out_write=0 during rst; any held token is discarded.
  - out_din is 0 after reset.
- tag_err clears only on rst.
- FLUX=1: the tag field (1 bit) is ignored and every token goes to flux 0.

Test Plan:
1. Reset: with rst=1 for 2 cycles and in_empty=0, in_read=0 and out_write=0 throughout; after release, tag_err=0 and the first read occurs in the first cycle after rst falls.
2. Streaming (FLUX=2, DATA_WIDTH=8): tokens {1,0x05},{0,0x0A},{1,0x07} are available back-to-back with no full.
   - in_read is high for 3 consecutive cycles.
   - out_write = 10 (0x05), 01 (0x0A), 10 (0x07) on the following 3 cycles.
3. Backpressure: token {1,0x33} held while out_full=10.
   - out_write=00 and in_read=0 for the 5 cycles out_full is high.
   - When out_full=00: 0x33 is written exactly once, the next token is read in the same cycle, and no loss or duplication occurs.
4. Frame marker (NUM_OP=4): 8 tokens to flux 0 interleaved with 3 tokens to flux 1.
   - out_last[0] is high only on the 4th and 8th flux-0 writes.
   - out_last[1] is never high.
   - A 4th flux-1 token then asserts out_last[1].
5. Illegal tag (FLUX=3): token {3,0x44} is consumed (in_read=1), no out_write occurs, and tag_err=1 holds through subsequent legal traffic until rst.
6. Reset mid-operation: token held under out_full=01, plus 2 flux-0 writes already counted; assert rst for 1 cycle.
   - The held token is never written.
   - After release, 4 flux-0 writes are needed before out_last[0] (counter restored).
